pipe_controller: RTL and testbench

PIPE_CONTROLLER -- requirements
Module: pipe_controller

---
 rtl/pipe_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_pipe_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipe_controller
// Purpose  : Pipeline sequencing and instruction-decode controller. Tracks the
//            run state (IDLE/STARTING/COMPUTING/DRAIN/ERROR), decodes the 5-bit
//            opcode/function field into registered datapath enables and
//            flow-control strobes, inserts stall and post-redirect bubbles,
//            and drains the pipeline after halt.
// Ports    : clk, rst (async, active-high)
//            start, halt, stall, opcodeFunc[4:0], Cin, Zin, pc[PC_W-1:0]
//            regWriteEn, memWriteEn, immAndmem, ldm, stm, cWriteEn, zWriteEn,
//            branch, jmp, push, pop, ret, aluOp[3:0], pcEn, flush (registered)
//            busy (combinational from state), err (sticky stack fault)
// Options  : CTRL_STACK_GUARD_EN -- when defined, a call-depth counter
//            traps call overflow / return underflow into the ERROR state.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_controller #(
    parameter int PC_W        = 12,
    parameter int PIPE_DEPTH  = 3,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt,
    input  logic            stall,
    input  logic [4:0]      opcodeFunc,
    input  logic            Cin,
    input  logic            Zin,
    input  logic [PC_W-1:0] pc,
    output logic            regWriteEn,
    output logic            memWriteEn,
    output logic            immAndmem,
    output logic            ldm,
    output logic            stm,
    output logic            cWriteEn,
    output logic            zWriteEn,
    output logic            branch,
    output logic            jmp,
    output logic            push,
    output logic            pop,
    output logic            ret,
    output logic [3:0]      aluOp,
    output logic            pcEn,
    output logic            flush,
    output logic            busy,
    output logic            err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_STARTING  = 3'd1;
    localparam logic [2:0] S_COMPUTING = 3'd2;
    localparam logic [2:0] S_DRAIN     = 3'd3;
    localparam logic [2:0] S_ERROR     = 3'd4;

    logic [2:0] r_state;
    logic [3:0] r_drain;

    // Combinational decode of the current opcode
    logic [3:0] w_alu;
    logic       w_rw, w_mw, w_im, w_ldm, w_stm, w_cw, w_zw;
    logic       w_br, w_jmp, w_push, w_pop, w_ret;
    logic       w_redirect;
    logic       w_slot;
    logic       w_fault;
    logic       w_unused_dbg;

    always_comb begin
        w_alu  = 4'b0000;
        w_rw   = 1'b0;
        w_mw   = 1'b0;
        w_im   = 1'b0;
        w_ldm  = 1'b0;
        w_stm  = 1'b0;
        w_cw   = 1'b0;
        w_zw   = 1'b0;
        w_br   = 1'b0;
        w_jmp  = 1'b0;
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_ret  = 1'b0;
        if (!opcodeFunc[4]) begin
            // 00xxx register ALU ops, 01xxx the same with immediate operand
            w_alu = {1'b0, opcodeFunc[2:0]};
            w_rw  = 1'b1;
            w_cw  = 1'b1;
            w_zw  = 1'b1;
            w_im  = opcodeFunc[3];
        end else begin
            case (opcodeFunc[3:0])
                4'b1000, 4'b1001: begin
                    w_alu = {3'b100, opcodeFunc[0]};
                    w_rw  = 1'b1;
                    w_cw  = 1'b1;
                    w_zw  = 1'b1;
                end
                4'b1010, 4'b1011: begin
                    // logic-type ops leave carry untouched
                    w_alu = {3'b101, opcodeFunc[0]};
                    w_rw  = 1'b1;
                    w_zw  = 1'b1;
                end
                4'b0000: begin
                    w_rw  = 1'b1;
                    w_im  = 1'b1;
                    w_ldm = 1'b1;
                end
                4'b0001: begin
                    w_mw  = 1'b1;
                    w_im  = 1'b1;
                    w_stm = 1'b1;
                end
                4'b0100: w_br = Zin;
                4'b0101: w_br = ~Zin;
                4'b0110: w_br = Cin;
                4'b0111: w_br = ~Cin;
                4'b1100: w_jmp = 1'b1;
                4'b1101: begin
                    w_jmp  = 1'b1;
                    w_push = 1'b1;
                end
                4'b1110: begin
                    w_pop = 1'b1;
                    w_ret = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_redirect = w_br | w_jmp | w_ret;

    // An instruction may issue only in COMPUTING with no halt, no stall, and
    // not in the slot right after a redirect (flush still high from it).
    assign w_slot = (r_state == S_COMPUTING) && !halt && !stall && !flush;

`ifdef CTRL_STACK_GUARD_EN
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [DW-1:0] r_depth;
    logic          r_err;

    assign w_fault = w_slot && ((w_push && (r_depth == DW'(STACK_DEPTH))) ||
                                (w_pop  && (r_depth == '0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_fault) begin
                r_err <= 1'b1;
            end else if (w_slot && w_push) begin
                r_depth <= r_depth + 1'b1;
            end else if (w_slot && w_pop) begin
                r_depth <= r_depth - 1'b1;
            end
        end
    end

    assign err          = r_err;
    assign w_unused_dbg = ^pc;
`else
    assign w_fault      = 1'b0;
    assign err          = 1'b0;
    assign w_unused_dbg = ^{pc, 1'(STACK_DEPTH)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_drain    <= '0;
            aluOp      <= 4'b0000;
            regWriteEn <= 1'b0;
            memWriteEn <= 1'b0;
            immAndmem  <= 1'b0;
            ldm        <= 1'b0;
            stm        <= 1'b0;
            cWriteEn   <= 1'b0;
            zWriteEn   <= 1'b0;
            branch     <= 1'b0;
            jmp        <= 1'b0;
            push       <= 1'b0;
            pop        <= 1'b0;
            ret        <= 1'b0;
            pcEn       <= 1'b0;
            flush      <= 1'b0;
        end else begin
            // Controls are single-cycle: cleared unless this edge issues
            aluOp      <= 4'b0000;
            regWriteEn <= 1'b0;
            memWriteEn <= 1'b0;
            immAndmem  <= 1'b0;
            ldm        <= 1'b0;
            stm        <= 1'b0;
            cWriteEn   <= 1'b0;
            zWriteEn   <= 1'b0;
            branch     <= 1'b0;
            jmp        <= 1'b0;
            push       <= 1'b0;
            pop        <= 1'b0;
            ret        <= 1'b0;
            pcEn       <= 1'b0;
            flush      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_STARTING;
                end
                S_STARTING: begin
                    if (!start) r_state <= S_COMPUTING;
                end
                S_COMPUTING: begin
                    if (halt) begin
                        r_state <= S_DRAIN;
                        r_drain <= 4'(PIPE_DEPTH - 1);
                    end else if (w_fault) begin
                        r_state <= S_ERROR;
                    end else if (w_slot) begin
                        aluOp      <= w_alu;
                        regWriteEn <= w_rw;
                        memWriteEn <= w_mw;
                        immAndmem  <= w_im;
                        ldm        <= w_ldm;
                        stm        <= w_stm;
                        cWriteEn   <= w_cw;
                        zWriteEn   <= w_zw;
                        branch     <= w_br;
                        jmp        <= w_jmp;
                        push       <= w_push;
                        pop        <= w_pop;
                        ret        <= w_ret;
                        pcEn       <= 1'b1;
                        flush      <= w_redirect;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == 4'd0) r_state <= S_IDLE;
                    else                 r_drain <= r_drain - 4'd1;
                end
                S_ERROR: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pipe_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_controller
// Purpose  : Scoreboard bench for pipe_controller. Directed scenarios followed
//            by randomized traffic; a reference model predicts the output set
//            for each clock edge, a separate monitor compares on negedge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_controller;

    localparam int PC_W        = 12;
    localparam int PIPE_DEPTH  = 3;
    localparam int STACK_DEPTH = 2;
`ifdef CTRL_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam logic [4:0] NOP = 5'd18;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0, halt = 1'b0, stall = 1'b0;
    logic            Cin = 1'b0, Zin = 1'b0;
    logic [4:0]      opcodeFunc = NOP;
    logic [PC_W-1:0] pc = '0;
    logic            regWriteEn, memWriteEn, immAndmem, ldm, stm, cWriteEn, zWriteEn;
    logic            branch, jmp, push, pop, ret, pcEn, flush, busy, err;
    logic [3:0]      aluOp;

    always #5 clk = ~clk;

    pipe_controller #(
        .PC_W(PC_W), .PIPE_DEPTH(PIPE_DEPTH), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .stall(stall),
        .opcodeFunc(opcodeFunc), .Cin(Cin), .Zin(Zin), .pc(pc),
        .regWriteEn(regWriteEn), .memWriteEn(memWriteEn), .immAndmem(immAndmem),
        .ldm(ldm), .stm(stm), .cWriteEn(cWriteEn), .zWriteEn(zWriteEn),
        .branch(branch), .jmp(jmp), .push(push), .pop(pop), .ret(ret),
        .aluOp(aluOp), .pcEn(pcEn), .flush(flush), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [3:0] alu;
        logic rw, mw, im, ldm, stm, cw, zw, br, jmp, push, pop, ret;
        logic pcen, flush, busy, err;
    } outv_t;

    typedef struct packed {
        logic rst, start, halt, stall;
        logic [4:0] op;
        logic c, z;
    } in_t;

    typedef enum int {M_IDLE, M_WAIT_RELEASE, M_RUN, M_DRAIN, M_FAULT} mode_t;

    outv_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    mode_t m_mode;
    int    m_left;
    int    m_depth;
    bit    m_squash;
    bit    m_err;
    in_t   saved;

    function automatic in_t mk(logic r, logic s, logic h, logic st,
                               logic [4:0] op, logic c, logic z);
        in_t x;
        x.rst = r; x.start = s; x.halt = h; x.stall = st;
        x.op = op; x.c = c; x.z = z;
        return x;
    endfunction

    // Instruction-set table: what a given opcode asks the datapath to do
    function automatic outv_t decode_ref(logic [4:0] op, logic c, logic z);
        outv_t d;
        int    v;
        d = '0;
        v = int'(op);
        if (v < 8) begin
            d.alu = 4'(v); d.rw = 1'b1; d.cw = 1'b1; d.zw = 1'b1;
        end else if (v < 16) begin
            d.alu = 4'(v - 8); d.rw = 1'b1; d.cw = 1'b1; d.zw = 1'b1; d.im = 1'b1;
        end else begin
            case (v)
                24, 25: begin d.alu = 4'(v - 16); d.rw = 1'b1; d.cw = 1'b1; d.zw = 1'b1; end
                26, 27: begin d.alu = 4'(v - 16); d.rw = 1'b1; d.zw = 1'b1; end
                16: begin d.rw = 1'b1; d.im = 1'b1; d.ldm = 1'b1; end
                17: begin d.mw = 1'b1; d.im = 1'b1; d.stm = 1'b1; end
                20: d.br = z;
                21: d.br = !z;
                22: d.br = c;
                23: d.br = !c;
                28: d.jmp = 1'b1;
                29: begin d.jmp = 1'b1; d.push = 1'b1; end
                30: begin d.pop = 1'b1; d.ret = 1'b1; end
                default: ;
            endcase
        end
        return d;
    endfunction

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_left   = 0;
        m_depth  = 0;
        m_squash = 1'b0;
        m_err    = 1'b0;
    endtask

    // Effect of one clock edge with inputs x; returns the outputs that follow
    task automatic model_step(input in_t x, output outv_t o);
        outv_t d;
        o = '0;
        if (x.rst) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE:         if (x.start) m_mode = M_WAIT_RELEASE;
            M_WAIT_RELEASE: if (!x.start) m_mode = M_RUN;
            M_RUN: begin
                if (x.halt) begin
                    m_mode = M_DRAIN;
                    m_left = PIPE_DEPTH - 1;
                end else if (!x.stall && !m_squash) begin
                    d = decode_ref(x.op, x.c, x.z);
                    if (GUARD && d.push && m_depth == STACK_DEPTH) begin
                        m_mode = M_FAULT; m_err = 1'b1;
                    end else if (GUARD && d.pop && m_depth == 0) begin
                        m_mode = M_FAULT; m_err = 1'b1;
                    end else begin
                        o       = d;
                        o.pcen  = 1'b1;
                        o.flush = d.br | d.jmp | d.ret;
                        m_depth = m_depth + int'(d.push) - int'(d.pop);
                    end
                end
            end
            M_DRAIN: begin
                if (m_left == 0) m_mode = M_IDLE;
                else             m_left = m_left - 1;
            end
            default: ;
        endcase
        m_squash = o.flush;
        o.busy   = (m_mode != M_IDLE);
        o.err    = m_err;
    endtask

    // One clock of stimulus: account for the edge just taken, then apply x
    task automatic cycle(input in_t x);
        outv_t e;
        @(posedge clk);
        #1;
        if (x.rst) begin
            model_reset();
            e = '0;
        end else begin
            model_step(saved, e);
        end
        exp_q.push_back(e);
        rst        = x.rst;
        start      = x.start;
        halt       = x.halt;
        stall      = x.stall;
        opcodeFunc = x.op;
        Cin        = x.c;
        Zin        = x.z;
        pc         = PC_W'($urandom);
        saved      = x;
    endtask

    // Monitor: compares whatever expectation is pending against the DUT
    always @(negedge clk) begin
        outv_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {aluOp, regWriteEn, memWriteEn, immAndmem, ldm, stm, cWriteEn,
                 zWriteEn, branch, jmp, push, pop, ret, pcEn, flush, busy, err};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL outputs t=%0t: got %05h required %05h", $time, a, e);
        end
    end

    initial begin
        saved = mk(1'b1, 1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0);
        model_reset();

        // reset, then start pulse into COMPUTING
        cycle(mk(1, 0, 0, 0, NOP, 0, 0));
        cycle(mk(1, 0, 0, 0, NOP, 0, 0));
        cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        cycle(mk(0, 1, 0, 0, NOP, 0, 0));
        cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        // immediate ALU op
        cycle(mk(0, 0, 0, 0, 5'b01010, 0, 0));
        // taken branch, squashed slot, not-taken branch
        cycle(mk(0, 0, 0, 0, 5'b10100, 0, 1));
        cycle(mk(0, 0, 0, 0, 5'b00001, 0, 0));
        cycle(mk(0, 0, 0, 0, 5'b10100, 0, 0));
        // stalled store
        cycle(mk(0, 0, 0, 1, 5'b10001, 0, 0));
        cycle(mk(0, 0, 0, 1, 5'b10001, 0, 0));
        cycle(mk(0, 0, 0, 0, 5'b10001, 0, 0));
        cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        // halt and drain, start ignored while draining
        cycle(mk(0, 0, 1, 0, 5'b00011, 0, 0));
        cycle(mk(0, 1, 0, 0, NOP, 0, 0));
        for (int i = 0; i < 4; i++) cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        // nested calls beyond the stack depth
        cycle(mk(0, 1, 0, 0, NOP, 0, 0));
        cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        for (int i = 0; i < 3; i++) begin
            cycle(mk(0, 0, 0, 0, 5'b11101, 0, 0));
            cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        end
        cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        // reset out of whatever state, then return at depth zero
        cycle(mk(1, 0, 0, 0, NOP, 0, 0));
        cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        cycle(mk(0, 1, 0, 0, NOP, 0, 0));
        cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        cycle(mk(0, 0, 0, 0, 5'b11110, 0, 0));
        cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        cycle(mk(1, 0, 0, 0, NOP, 0, 0));

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(mk(logic'($urandom_range(0, 149) == 0),
                     logic'($urandom_range(0, 3) == 0),
                     logic'($urandom_range(0, 24) == 0),
                     logic'($urandom_range(0, 4) == 0),
                     5'($urandom), 1'($urandom), 1'($urandom)));
        end
        cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        cycle(mk(0, 0, 0, 0, NOP, 0, 0));
        @(negedge clk);
        @(posedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: got %0d pending required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
